// File: rtl/clks_alot_p.sv
// Shared types and defaults for the multi-channel pausable clock generator.
package clks_alot_p;

    localparam int unsigned DEFAULT_RATE_COUNTER_WIDTH = 16;
    localparam int unsigned LOCK_COUNT_WIDTH           = 4;

    typedef enum logic [1:0] {
        RUNNING,
        PAUSE_PENDING,
        PAUSED,
        RESUME_PENDING
    } pause_state_e;

    typedef struct packed {
        logic                                  pause_active;
        logic [DEFAULT_RATE_COUNTER_WIDTH-1:0] pause_duration;
        logic                                  locked;
    } channel_status_s;

    typedef struct packed {
        logic rise;
        logic fall;
    } channel_events_s;

endpackage

// File: rtl/pausable_clock_channel.sv
// One clock channel: half-period divider, lock counter, glitch-free pause FSM
// and pause-duration counter.
module pausable_clock_channel
    import clks_alot_p::*;
#(
    parameter int unsigned RATE_COUNTER_WIDTH = DEFAULT_RATE_COUNTER_WIDTH,
    parameter int unsigned LOCK_TOGGLES       = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clk_en,
    input  logic                          generation_en,
    input  logic                          init,
    input  logic                          starting_polarity,
    input  logic [RATE_COUNTER_WIDTH-1:0] half_period,
    input  logic                          pause_en,
    input  logic                          pause_polarity,
    output logic                          unpausable_clk,
    output logic                          pausable_clk,
    output channel_events_s               events,
    output logic                          pause_active,
    output logic [RATE_COUNTER_WIDTH-1:0] pause_duration,
    output logic                          locked
);

    localparam int unsigned W  = RATE_COUNTER_WIDTH;
    localparam int unsigned LW = LOCK_COUNT_WIDTH;

    pause_state_e    state_q, state_d;
    logic [W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]    dur_d;
    logic [W-1:0]    terminal;
    logic [LW-1:0]   tcnt_q, tcnt_d;
    logic            unp_d, pau_d, active_d, locked_d, tog;
    channel_events_s events_d;

    // State and registered outputs advance only on enabled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUNNING;
            cnt_q          <= '0;
            tcnt_q         <= '0;
            unpausable_clk <= 1'b0;
            pausable_clk   <= 1'b0;
            events         <= '0;
            pause_active   <= 1'b0;
            pause_duration <= '0;
            locked         <= 1'b0;
        end else if (clk_en) begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tcnt_q         <= tcnt_d;
            unpausable_clk <= unp_d;
            pausable_clk   <= pau_d;
            events         <= events_d;
            pause_active   <= active_d;
            pause_duration <= dur_d;
            locked         <= locked_d;
        end else begin
            events         <= '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tcnt_d   = tcnt_q;
        dur_d    = pause_duration;
        terminal = (half_period == '0) ? '0 : half_period - W'(1);
        tog      = generation_en && (cnt_q == terminal);
        unp_d    = unpausable_clk ^ tog;
        pau_d    = unp_d;

        if (generation_en) begin
            cnt_d = tog ? '0 : cnt_q + W'(1);
        end
        if (tog && (tcnt_q < LW'(LOCK_TOGGLES))) begin
            tcnt_d = tcnt_q + LW'(1);
        end

        // Pause decisions look at the pre-toggle level so held phases never shrink.
        case (state_q)
            RUNNING: begin
                if (pause_en) begin
                    if (pausable_clk == pause_polarity) begin
                        state_d = PAUSED;
                        pau_d   = pausable_clk;
                    end else begin
                        state_d = PAUSE_PENDING;
                    end
                end
            end
            PAUSE_PENDING: begin
                if (!pause_en) begin
                    state_d = RUNNING;
                end else if (tog && (unp_d == pause_polarity)) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                pau_d = pause_polarity;
                if (!pause_en) begin
                    state_d = RESUME_PENDING;
                end
            end
            RESUME_PENDING: begin
                pau_d = pause_polarity;
                if (pause_en) begin
                    state_d = PAUSED;
                end else if (tog && (unp_d != pause_polarity)) begin
                    state_d = RUNNING;
                    pau_d   = unp_d;
                end
            end
            default: state_d = RUNNING;
        endcase

        if ((state_q == PAUSED) || (state_q == RESUME_PENDING)) begin
            dur_d = (pause_duration != '1) ? pause_duration + W'(1) : pause_duration;
        end
        if ((state_q == RESUME_PENDING) && (state_d == RUNNING)) begin
            dur_d = '0;
        end

        // Restart wins over every other event on the same cycle.
        if (init) begin
            state_d = RUNNING;
            cnt_d   = '0;
            tcnt_d  = '0;
            dur_d   = '0;
            unp_d   = starting_polarity;
            pau_d   = starting_polarity;
        end

        active_d      = (state_d == PAUSED) || (state_d == RESUME_PENDING);
        locked_d      = !init && generation_en && (tcnt_d >= LW'(LOCK_TOGGLES));
        events_d.rise = !init && pau_d && !pausable_clk;
        events_d.fall = !init && !pau_d && pausable_clk;
    end

endmodule

// File: rtl/multi_pausable_clock_gen.sv
// N independent pausable clock channels sharing a system clock and a common
// synchronous restart.
module multi_pausable_clock_gen
    import clks_alot_p::*;
#(
    parameter int unsigned NUM_CHANNELS       = 4,
    parameter int unsigned RATE_COUNTER_WIDTH = DEFAULT_RATE_COUNTER_WIDTH,
    parameter int unsigned LOCK_TOGGLES       = 2
) (
    input  logic                                       clk,
    input  logic                                       async_rst_n,
    input  logic                                       clk_en,
    input  logic [NUM_CHANNELS-1:0]                    generation_en_i,
    input  logic [NUM_CHANNELS-1:0]                    init_i,
    input  logic                                       sync_init_i,
    input  logic [NUM_CHANNELS-1:0]                    starting_polarity_i,
    input  logic [NUM_CHANNELS*RATE_COUNTER_WIDTH-1:0] half_period_i,
    input  logic [NUM_CHANNELS-1:0]                    pause_en_i,
    input  logic [NUM_CHANNELS-1:0]                    pause_polarity_i,
    output logic [NUM_CHANNELS-1:0]                    unpausable_clk_o,
    output logic [NUM_CHANNELS-1:0]                    pausable_clk_o,
    output logic [NUM_CHANNELS-1:0]                    rise_o,
    output logic [NUM_CHANNELS-1:0]                    fall_o,
    output logic [NUM_CHANNELS-1:0]                    pause_active_o,
    output logic [NUM_CHANNELS*RATE_COUNTER_WIDTH-1:0] pause_duration_o,
    output logic [NUM_CHANNELS-1:0]                    locked_o
);

    localparam int unsigned W = RATE_COUNTER_WIDTH;

    channel_events_s events [NUM_CHANNELS];

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_channel
        pausable_clock_channel #(
            .RATE_COUNTER_WIDTH (W),
            .LOCK_TOGGLES       (LOCK_TOGGLES)
        ) u_channel (
            .clk               (clk),
            .rst_n             (async_rst_n),
            .clk_en            (clk_en),
            .generation_en     (generation_en_i[c]),
            .init              (init_i[c] | sync_init_i),
            .starting_polarity (starting_polarity_i[c]),
            .half_period       (half_period_i[c*W +: W]),
            .pause_en          (pause_en_i[c]),
            .pause_polarity    (pause_polarity_i[c]),
            .unpausable_clk    (unpausable_clk_o[c]),
            .pausable_clk      (pausable_clk_o[c]),
            .events            (events[c]),
            .pause_active      (pause_active_o[c]),
            .pause_duration    (pause_duration_o[c*W +: W]),
            .locked            (locked_o[c])
        );

        assign rise_o[c] = events[c].rise;
        assign fall_o[c] = events[c].fall;
    end

endmodule

// File: tb/tb_multi_pausable_clock_gen.sv
// Directed bench for multi_pausable_clock_gen: two channels, 4-bit counters.
module tb_multi_pausable_clock_gen;

    localparam int unsigned N  = 2;
    localparam int unsigned W  = 4;
    localparam int unsigned LT = 2;

    logic           clk = 1'b0;
    logic           async_rst_n;
    logic           clk_en;
    logic [N-1:0]   generation_en_i, init_i, starting_polarity_i;
    logic [N-1:0]   pause_en_i, pause_polarity_i;
    logic           sync_init_i;
    logic [N*W-1:0] half_period_i;
    logic [N-1:0]   unpausable_clk_o, pausable_clk_o, rise_o, fall_o;
    logic [N-1:0]   pause_active_o, locked_o;
    logic [N*W-1:0] pause_duration_o;

    int vectors     = 0;
    int miscompares = 0;

    multi_pausable_clock_gen #(
        .NUM_CHANNELS       (N),
        .RATE_COUNTER_WIDTH (W),
        .LOCK_TOGGLES       (LT)
    ) dut (
        .clk                 (clk),
        .async_rst_n         (async_rst_n),
        .clk_en              (clk_en),
        .generation_en_i     (generation_en_i),
        .init_i              (init_i),
        .sync_init_i         (sync_init_i),
        .starting_polarity_i (starting_polarity_i),
        .half_period_i       (half_period_i),
        .pause_en_i          (pause_en_i),
        .pause_polarity_i    (pause_polarity_i),
        .unpausable_clk_o    (unpausable_clk_o),
        .pausable_clk_o      (pausable_clk_o),
        .rise_o              (rise_o),
        .fall_o              (fall_o),
        .pause_active_o      (pause_active_o),
        .pause_duration_o    (pause_duration_o),
        .locked_o            (locked_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_ch0(input logic [W-1:0] half, input logic pol, input logic pp);
        half_period_i[W-1:0]   = half;
        starting_polarity_i[0] = pol;
        pause_polarity_i[0]    = pp;
        pause_en_i[0]          = 1'b0;
        init_i[0]              = 1'b1;
        tick();
        init_i[0]              = 1'b0;
    endtask

    task automatic test_reset();
        async_rst_n         = 1'b0;
        clk_en              = 1'b1;
        generation_en_i     = '1;
        init_i              = '0;
        sync_init_i         = 1'b0;
        starting_polarity_i = '0;
        half_period_i       = '0;
        pause_en_i          = '0;
        pause_polarity_i    = '0;
        #3;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({unpausable_clk_o, pausable_clk_o, rise_o, fall_o, pause_active_o, locked_o,
                 pause_duration_o} !== 20'h0) begin
                miscompares++;
                $display("FAIL reset[%0d] outputs=%b required all zero", i,
                         {unpausable_clk_o, pausable_clk_o, rise_o, fall_o, pause_active_o,
                          locked_o, pause_duration_o});
            end
            tick();
        end
        async_rst_n = 1'b1;
    endtask

    task automatic test_divider_lock();
        logic eu, er, ef, el;
        init_ch0(4'd3, 1'b0, 1'b0);
        vectors++;
        if ({unpausable_clk_o[0], pausable_clk_o[0], locked_o[0]} !== 3'b000) begin
            miscompares++;
            $display("FAIL div_init got=%b required=000",
                     {unpausable_clk_o[0], pausable_clk_o[0], locked_o[0]});
        end
        for (int k = 1; k <= 13; k++) begin
            tick();
            eu = ((k / 3) % 2) == 1;
            er = (k == 3) || (k == 9);
            ef = (k == 6) || (k == 12);
            el = (k >= 6);
            vectors++;
            if ({unpausable_clk_o[0], pausable_clk_o[0], rise_o[0], fall_o[0], locked_o[0]}
                    !== {eu, eu, er, ef, el}) begin
                miscompares++;
                $display("FAIL div3 k=%0d got u/p/r/f/l=%b required=%b", k,
                         {unpausable_clk_o[0], pausable_clk_o[0], rise_o[0], fall_o[0],
                          locked_o[0]}, {eu, eu, er, ef, el});
            end
        end
        init_ch0(4'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            eu = (k % 2) == 1;
            vectors++;
            if ({unpausable_clk_o[0], rise_o[0], fall_o[0]} !== {eu, eu, !eu}) begin
                miscompares++;
                $display("FAIL div0 k=%0d got u/r/f=%b required=%b", k,
                         {unpausable_clk_o[0], rise_o[0], fall_o[0]}, {eu, eu, !eu});
            end
        end
    endtask

    task automatic test_pause_from_high();
        logic         ep, er, ef, ea;
        logic [W-1:0] ed;
        init_ch0(4'd3, 1'b0, 1'b1);
        for (int k = 1; k <= 21; k++) begin
            pause_en_i[0] = (k <= 13);
            tick();
            ep = ((k >= 3) && (k <= 17)) || (k == 21);
            er = (k == 3) || (k == 21);
            ef = (k == 18);
            ea = (k >= 3) && (k <= 17);
            ed = ((k >= 4) && (k <= 17)) ? W'(k - 3) : '0;
            vectors++;
            if ({pausable_clk_o[0], rise_o[0], fall_o[0], pause_active_o[0]} !== {ep, er, ef, ea}
                    || pause_duration_o[W-1:0] !== ed) begin
                miscompares++;
                $display("FAIL pause_high k=%0d got p/r/f/a=%b dur=%0d required=%b dur=%0d", k,
                         {pausable_clk_o[0], rise_o[0], fall_o[0], pause_active_o[0]},
                         pause_duration_o[W-1:0], {ep, er, ef, ea}, ed);
            end
        end
    endtask

    task automatic test_pause_abort();
        logic eu, er, ef;
        init_ch0(4'd3, 1'b0, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            pause_en_i[0] = (k == 1);
            tick();
            eu = ((k / 3) % 2) == 1;
            er = (k == 3) || (k == 9);
            ef = (k == 6);
            vectors++;
            if ({pausable_clk_o[0], unpausable_clk_o[0], pause_active_o[0], rise_o[0], fall_o[0]}
                    !== {eu, eu, 1'b0, er, ef}) begin
                miscompares++;
                $display("FAIL pause_abort k=%0d got p/u/a/r/f=%b required=%b", k,
                         {pausable_clk_o[0], unpausable_clk_o[0], pause_active_o[0], rise_o[0],
                          fall_o[0]}, {eu, eu, 1'b0, er, ef});
            end
        end
        pause_en_i[0] = 1'b0;
    endtask

    task automatic test_saturation();
        logic         ep, ea;
        logic [W-1:0] ed;
        init_ch0(4'd3, 1'b0, 1'b0);
        for (int k = 1; k <= 45; k++) begin
            pause_en_i[0] = (k <= 40);
            tick();
            ep = (k == 45);
            ea = (k <= 44);
            ed = ((k >= 2) && (k <= 44)) ? ((k - 1 > 15) ? 4'd15 : W'(k - 1)) : '0;
            vectors++;
            if ({pausable_clk_o[0], rise_o[0], pause_active_o[0]} !== {ep, ep, ea}
                    || pause_duration_o[W-1:0] !== ed) begin
                miscompares++;
                $display("FAIL saturation k=%0d got p/r/a=%b dur=%0d required=%b dur=%0d", k,
                         {pausable_clk_o[0], rise_o[0], pause_active_o[0]},
                         pause_duration_o[W-1:0], {ep, ep, ea}, ed);
            end
        end
    endtask

    task automatic test_multi_sync();
        logic [N-1:0] eu, el;
        pause_en_i       = '0;
        pause_polarity_i = '0;
        half_period_i    = {4'd5, 4'd2};
        for (int k = 0; k < 12; k++) tick();
        vectors++;
        if (locked_o !== 2'b11) begin
            miscompares++;
            $display("FAIL sync_prelock got=%b required=11", locked_o);
        end
        starting_polarity_i = 2'b01;
        sync_init_i         = 1'b1;
        tick();
        sync_init_i         = 1'b0;
        vectors++;
        if ({unpausable_clk_o, pausable_clk_o, locked_o} !== 6'b01_01_00) begin
            miscompares++;
            $display("FAIL sync_load got u/p/l=%b required=010100",
                     {unpausable_clk_o, pausable_clk_o, locked_o});
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            eu[0] = ((k / 2) % 2) == 0;
            eu[1] = ((k / 5) % 2) == 1;
            el    = (k >= 4) ? 2'b01 : 2'b00;
            vectors++;
            if ({unpausable_clk_o, locked_o} !== {eu, el}) begin
                miscompares++;
                $display("FAIL sync_run k=%0d got u/l=%b required=%b", k,
                         {unpausable_clk_o, locked_o}, {eu, el});
            end
        end
    endtask

    task automatic test_clk_en_and_reset();
        half_period_i = {4'd5, 4'd3};
        init_ch0(4'd3, 1'b0, 1'b0);
        pause_en_i[0] = 1'b1;
        for (int k = 1; k <= 5; k++) tick();
        vectors++;
        if ({unpausable_clk_o[0], pause_active_o[0]} !== 2'b11 || pause_duration_o[W-1:0] !== 4'd4) begin
            miscompares++;
            $display("FAIL clken_pre got u/a=%b dur=%0d required=11 dur=4",
                     {unpausable_clk_o[0], pause_active_o[0]}, pause_duration_o[W-1:0]);
        end
        clk_en = 1'b0;
        for (int k = 6; k <= 12; k++) begin
            tick();
            vectors++;
            if ({unpausable_clk_o[0], pausable_clk_o[0], pause_active_o[0]} !== 3'b101
                    || pause_duration_o[W-1:0] !== 4'd4) begin
                miscompares++;
                $display("FAIL clken_frozen k=%0d got u/p/a=%b dur=%0d required=101 dur=4", k,
                         {unpausable_clk_o[0], pausable_clk_o[0], pause_active_o[0]},
                         pause_duration_o[W-1:0]);
            end
        end
        clk_en = 1'b1;
        tick();
        vectors++;
        if (unpausable_clk_o[0] !== 1'b0 || pause_duration_o[W-1:0] !== 4'd5) begin
            miscompares++;
            $display("FAIL clken_resume got u=%b dur=%0d required u=0 dur=5",
                     unpausable_clk_o[0], pause_duration_o[W-1:0]);
        end
        #2;
        async_rst_n = 1'b0;
        #1;
        vectors++;
        if ({unpausable_clk_o, pausable_clk_o, rise_o, fall_o, pause_active_o, locked_o,
             pause_duration_o} !== 20'h0) begin
            miscompares++;
            $display("FAIL async_reset outputs=%b required all zero",
                     {unpausable_clk_o, pausable_clk_o, rise_o, fall_o, pause_active_o, locked_o,
                      pause_duration_o});
        end
        tick();
        async_rst_n   = 1'b1;
        pause_en_i[0] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_divider_lock();
        test_pause_from_high();
        test_pause_abort();
        test_saturation();
        test_multi_sync();
        test_clk_en_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_pausable_clock_gen.md
Name: multi_pausable_clock_gen

Overview:
- Parametrised, N-channel successor to the single pausable clock generator.
- Each channel generates its own divided IO clock from a programmable half-period counter; no external toggle events are needed.
- Each channel drives an unpausable and a glitch-free pausable copy, plus edge events, lock status and a pause-duration counter.
- Sits between the clock-rate configuration registers and the IO serialisers; all outputs are in the system clock domain.

Parameters:
- NUM_CHANNELS, 4, number of independent clock channels (1..16).
- RATE_COUNTER_WIDTH, 16, width of the half-period and pause-duration counters.
- LOCK_TOGGLES, 2, toggle events after init before locked_o asserts (1..15).

Ports:
- clk  in  1  system clock.
- async_rst_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  system clock enable; all state advances only when high, except reset.
- generation_en_i  in  NUM_CHANNELS  per-channel generation enable.
- init_i  in  NUM_CHANNELS  per-channel restart pulse.
- sync_init_i  in  1  restarts all channels on the same cycle.
- starting_polarity_i  in  NUM_CHANNELS  level loaded on init.
- half_period_i  in  NUM_CHANNELS*RATE_COUNTER_WIDTH  system-clock cycles per half period; 0 is treated as 1.
- pause_en_i  in  NUM_CHANNELS  pause request, level-sensitive.
- pause_polarity_i  in  NUM_CHANNELS  level at which the pausable clock is held.
- unpausable_clk_o  out  NUM_CHANNELS  free-running divided clock.
- pausable_clk_o  out  NUM_CHANNELS  gated clock.
- rise_o / fall_o  out  NUM_CHANNELS each  one-cycle pulse when pausable_clk_o rises or falls.
- pause_active_o  out  NUM_CHANNELS  high while the channel is PAUSED or RESUME_PENDING.
- pause_duration_o  out  NUM_CHANNELS*RATE_COUNTER_WIDTH  enabled cycles spent paused.
- locked_o  out  NUM_CHANNELS  channel running and stable.

Behaviour:
- Reset (async_rst_n low), per channel:
  - outputs: clocks 0, events 0, pause_active 0, duration 0, locked 0.
  - internal: counter 0, FSM RUNNING.
- Init:
  - Trigger: init_i[c] or sync_init_i while clk_en is high.
  - Next cycle: unpausable = pausable = starting_polarity, counter 0, FSM RUNNING, duration 0, locked 0, toggle count 0.
  - Init overrides every other event on the same cycle.
- Divider (clk_en and generation_en high):
  - counter increments; at counter == max(half_period,1)-1 a toggle event fires and counter clears.
  - The toggle event inverts unpausable_clk_o, registered, so it is visible one cycle after the event.
  - A half_period change takes effect at the next compare; if the counter already exceeds the new value, it wraps at the full counter width.
- generation_en low: counter and clocks hold, no events, locked_o cleared. Re-enable resumes from the held state.
- Lock:
  - Saturating toggle count increments per toggle event.
  - locked_o = generation_en && count >= LOCK_TOGGLES.
- Pause FSM per channel (all transitions gated by clk_en):
  - RUNNING: pausable follows unpausable.
    - pause_en high, pausable == pause_polarity → PAUSED, holding the current level.
    - pause_en high, otherwise → PAUSE_PENDING.
  - PAUSE_PENDING: follows unpausable.
    - Toggle event whose next level == pause_polarity → PAUSED, with that edge passed through.
    - pause_en dropped first → RUNNING.
  - PAUSED: pausable held at pause_polarity; duration increments each enabled cycle, saturating at all-ones.
    - pause_en low → RESUME_PENDING.
  - RESUME_PENDING: still held.
    - Next toggle event where unpausable leaves pause_polarity → RUNNING, and that edge passes to the output.
    - pause_en re-asserted → PAUSED. Duration keeps counting and is not cleared.
  - Duration clears on the cycle RUNNING is entered from RESUME_PENDING, or on init.
- Glitch-free guarantee: no pausable_clk_o high or low phase is shorter than the configured half period.
- rise_o/fall_o are derived from the registered pausable output against its previous value, so they are one cycle wide and never fire while paused.
- Simultaneous pause_en and toggle event in RUNNING: the decision uses the pre-toggle level, so PAUSED holds the current level and the toggle is suppressed on the pausable output.
- Reset asserted mid-pause: immediate return to reset values.
- Channels are fully independent except through sync_init_i.

Decomposition:
- clks_alot_p package holds:
  - RATE_COUNTER_WIDTH default;
  - pause_state_e enum {RUNNING, PAUSE_PENDING, PAUSED, RESUME_PENDING};
  - channel_status_s {pause_active, pause_duration, locked};
  - channel_events_s {rise, fall}.
- One sub-module, pausable_clock_channel, containing the divider, lock counter, pause FSM and duration counter.
- The top generates NUM_CHANNELS instances and fans out sync_init_i.

Test Plan:
- Divider and lock: reset, init ch0 with half_period=3, polarity 0, gen_en=1.
  - Required: period 6 cycles; locked_o[0] rises on the cycle of the 2nd toggle.
  - Required: half_period=0 gives a toggle every cycle.
- Pause from high: pause_polarity=1, pause_en raised while the clock is low.
  - Required: held high after the next rise; rise_o still pulses once.
  - Required: duration counts 10 after 10 cycles.
  - On release, the output falls only on the next unpausable fall, and the first resumed low phase lasts exactly 3 cycles.
- Pause abort: pause_en high for 1 cycle in PAUSE_PENDING.
  - Required: returns to RUNNING with no waveform difference from the unpausable clock.
- Saturation: RATE_COUNTER_WIDTH=4, pause for 40 cycles.
  - Required: duration sticks at 15; it clears to 0 on resume.
- Multi-channel sync: ch0 half=2, ch1 half=5, free-running, then a sync_init_i pulse with polarities 1/0.
  - Required: both channels load on the same cycle; ch0 first toggle 2 cycles later, ch1 first toggle 5 cycles later; locked_o cleared on both.
- Async reset and clk_en:
  - async_rst_n asserted mid-PAUSED → all outputs 0 immediately.
  - clk_en low for 7 cycles → counters, FSM and duration frozen.
